neokeon_state_xor_constant: RTL and testbench

- Noekeon round-constant injection stage: XORs a 32-bit round constant into one 32-bit word of the 128-bit cipher state.
- The default word is a0, the most significant word, bits [127:96].
- Sits in the round datapath between the key/state XOR and Theta.
- Registered single stage with a valid flag, so the round pipeline can stall on inValid.

---
 rtl/neokeon_state_xor_constant.sv | 65 ++++++
 tb/tb_neokeon_state_xor_constant.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/neokeon_state_xor_constant.sv
// Noekeon round-constant injection stage.
// XORs a 32-bit round constant into one 32-bit word of the 128-bit state
// (a0 = [127:96] by default) and registers the result with a valid flag.
// Optional build macro: NEOKEON_CONST_MASK_EN -- when defined only the low
// byte of constant1 is applied (Noekeon's 8-bit round constant).
module neokeon_state_xor_constant #(
  parameter int unsigned CONST_WORD = 0
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inValid,
  input  logic [127:0] inDataState,
  input  logic [31:0]  constant1,
  output logic [127:0] outDataState,
  output logic         outValid
);

  // A word index outside 0..3 has no meaning; stop elaboration.
  if (CONST_WORD > 32'd3) begin : g_bad_const_word
    $error("neokeon_state_xor_constant: CONST_WORD must be 0..3");
  end

  logic [31:0]  eff_const_s;
  logic [127:0] xor_mask_s;
  logic [127:0] data_r;
  logic         valid_r;

`ifdef NEOKEON_CONST_MASK_EN
  // Only the round-constant byte is injected; upper bits are don't-care.
  logic unused_const_hi_s;
  assign unused_const_hi_s = ^constant1[31:8];
  assign eff_const_s       = {24'h000000, constant1[7:0]};
`else
  assign eff_const_s = constant1;
`endif

  // Place the effective constant over the selected word; other words see zero.
  always_comb begin
    xor_mask_s = 128'h0;
    case (CONST_WORD)
      32'd0:   xor_mask_s[127:96] = eff_const_s;
      32'd1:   xor_mask_s[95:64]  = eff_const_s;
      32'd2:   xor_mask_s[63:32]  = eff_const_s;
      32'd3:   xor_mask_s[31:0]   = eff_const_s;
      default: xor_mask_s         = 128'h0;
    endcase
  end

  // Result register: cleared on reset, loaded only on valid, otherwise held.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      data_r  <= 128'h0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= inValid;
      if (inValid) begin
        data_r <= inDataState ^ xor_mask_s;
      end
    end
  end

  assign outDataState = data_r;
  assign outValid     = valid_r;

endmodule

// File: tb/tb_neokeon_state_xor_constant.sv
// Directed bench for neokeon_state_xor_constant: word-0 and word-3 instances
// driven from shared inputs, hand-computed expected values.
module tb_neokeon_state_xor_constant;

  logic         inClk;
  logic         inRst;
  logic         inValid;
  logic [127:0] inDataState;
  logic [31:0]  constant1;
  logic [127:0] out0;
  logic         val0;
  logic [127:0] out3;
  logic         val3;

  int total;
  int bad;

  localparam logic [127:0] ST = 128'h2a78429b87c7d0924f26113f1d1349b2;

  neokeon_state_xor_constant #(.CONST_WORD(0)) u_w0 (
    .inClk(inClk), .inRst(inRst), .inValid(inValid),
    .inDataState(inDataState), .constant1(constant1),
    .outDataState(out0), .outValid(val0)
  );

  neokeon_state_xor_constant #(.CONST_WORD(3)) u_w3 (
    .inClk(inClk), .inRst(inRst), .inValid(inValid),
    .inDataState(inDataState), .constant1(constant1),
    .outDataState(out3), .outValid(val3)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle off the edge before sampling.
  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  initial begin
    logic [127:0] full_exp;
    logic [127:0] a0_exp [4];
    logic [31:0]  rc     [4];
    total = 0;
    bad = 0;
    rc[0] = 32'h00000080; rc[1] = 32'h0000001b; rc[2] = 32'h00000036; rc[3] = 32'h0000006c;
    a0_exp[0] = 128'h2a78421b87c7d0924f26113f1d1349b2;
    a0_exp[1] = 128'h2a78428087c7d0924f26113f1d1349b2;
    a0_exp[2] = 128'h2a7842ad87c7d0924f26113f1d1349b2;
    a0_exp[3] = 128'h2a7842f787c7d0924f26113f1d1349b2;
`ifdef NEOKEON_CONST_MASK_EN
    full_exp = 128'h2a78421b87c7d0924f26113f1d1349b2;
`else
    full_exp = 128'hd587bd1b87c7d0924f26113f1d1349b2;
`endif

    // Reset with valid and random data held high for two cycles.
    inRst = 1'b1; inValid = 1'b1;
    inDataState = {$urandom, $urandom, $urandom, $urandom};
    constant1 = $urandom;
    @(negedge inClk);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_data0", out0, 128'h0);
      chk("rst_valid0", {127'h0, val0}, 128'h0);
      chk("rst_data3", out3, 128'h0);
      inDataState = {$urandom, $urandom, $urandom, $urandom};
    end

    // Reset released, no valid yet: still zero.
    inRst = 1'b0; inValid = 1'b0;
    tick();
    chk("post_rst_data", out0, 128'h0);
    chk("post_rst_valid", {127'h0, val0}, 128'h0);

    // Reference vector on a0.
    inValid = 1'b1; inDataState = ST; constant1 = 32'h00000080;
    tick();
    chk("ref_data", out0, 128'h2a78421b87c7d0924f26113f1d1349b2);
    chk("ref_valid", {127'h0, val0}, 128'h1);
    inValid = 1'b0; inDataState = 128'h0; constant1 = 32'hffffffff;
    tick();
    chk("hold_valid", {127'h0, val0}, 128'h0);
    chk("hold_data", out0, 128'h2a78421b87c7d0924f26113f1d1349b2);

    // Full-width constant.
    inValid = 1'b1; inDataState = ST; constant1 = 32'hffffff80;
    tick();
    chk("full_data", out0, full_exp);
    chk("full_valid", {127'h0, val0}, 128'h1);

    // Four back-to-back round constants.
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inDataState = ST; constant1 = rc[i];
      tick();
      chk($sformatf("stream_data%0d", i), out0, a0_exp[i]);
      chk($sformatf("stream_valid%0d", i), {127'h0, val0}, 128'h1);
    end

    // Zero constant: identity on both instances.
    inValid = 1'b1; inDataState = ST; constant1 = 32'h00000000;
    tick();
    chk("zero_w0", out0, ST);
    chk("zero_w3", out3, ST);

    // Constant D4: word 3 only changes [31:0]; word 0 only changes [127:96].
    constant1 = 32'h000000d4;
    tick();
    chk("w3_data", out3, 128'h2a78429b87c7d0924f26113f1d134966);
    chk("w3_valid", {127'h0, val3}, 128'h1);
    chk("w0_d4", out0, 128'h2a78424f87c7d0924f26113f1d1349b2);

    // Reset in the cycle after a valid pulse discards the result.
    inValid = 1'b1; constant1 = 32'h00000080;
    tick();
    chk("pre_midrst", out0, 128'h2a78421b87c7d0924f26113f1d1349b2);
    inRst = 1'b1; inValid = 1'b0;
    tick();
    chk("midrst_data", out0, 128'h0);
    chk("midrst_valid", {127'h0, val0}, 128'h0);
    inRst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("after_midrst_data", out0, 128'h0);
      chk("after_midrst_valid", {127'h0, val0}, 128'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
